// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and helpers for the FIFO push arbiter.
package fifo_arb_pkg;
   typedef enum logic {IDLE, BUSY} state_e;
   // Never returns 0, so a single-value range still gets a 1-bit field.
   function automatic int clog2(input int v);
      int r;
      r = 1;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/fifo_push_arbiter_rr_pick.sv
// rr_pick: round-robin search for the first request after last_id, wrapping modulo N.
module rr_pick import fifo_arb_pkg::*; #(
   parameter int N  = 4,
   parameter int IW = clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last_id,
   output logic          found,
   output logic [IW-1:0] next_id
);
   // Scan from farthest to nearest so the closest candidate is assigned last and wins.
   always_comb begin
      found   = |req;
      next_id = last_id;
      for (int i = N; i >= 1; i--)
         if (req[IW'((int'(last_id) + i) % N)]) next_id = IW'((int'(last_id) + i) % N);
   end
endmodule

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: round-robin, burst-locked sharing of one FIFO push port among NUM_REQ producers.
module fifo_push_arbiter import fifo_arb_pkg::*; #(
   parameter int  NUM_REQ    = 4,
   parameter int  DATA_WIDTH = 2,
   parameter int  MAX_BURST  = 4,
   localparam int ID_WIDTH   = clog2(NUM_REQ),
   localparam int CNT_WIDTH  = clog2(MAX_BURST)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   output logic                          fifo_push,
   output logic [DATA_WIDTH-1:0]         fifo_din,
   output logic                          grant_valid,
   output logic [ID_WIDTH-1:0]           grant_id
);
   state_e                state_q, state_d;
   logic [ID_WIDTH-1:0]   grant_id_q, grant_id_d, last_id_q, last_id_d, pick_id;
   logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
   logic                  pick_found, busy, fire;
   rr_pick #(.N(NUM_REQ), .IW(ID_WIDTH)) u_pick (
      .req     (req_valid),
      .last_id (last_id_q),
      .found   (pick_found),
      .next_id (pick_id)
   );
   always_comb begin
      busy        = state_q == BUSY;
      fire        = busy && req_valid[grant_id_q] && !fifo_full;
      req_ready   = (busy && !fifo_full) ? NUM_REQ'(1) << grant_id_q : '0;
      fifo_push   = fire;
      grant_valid = busy;
      grant_id    = grant_id_q;
      fifo_din    = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (fire && grant_id_q == ID_WIDTH'(i)) fifo_din = req_data[i*DATA_WIDTH +: DATA_WIDTH];
   end
   // A full FIFO only stalls: grant and beat count hold until the grantee drops valid or bursts out.
   always_comb begin
      state_d    = state_q;
      grant_id_d = grant_id_q;
      last_id_d  = last_id_q;
      beat_cnt_d = beat_cnt_q;
      if (!busy) begin
         if (pick_found) begin
            state_d    = BUSY;
            grant_id_d = pick_id;
         end
      end else if (!req_valid[grant_id_q] || (fire && beat_cnt_q == CNT_WIDTH'(MAX_BURST - 1))) begin
         state_d    = IDLE;
         last_id_d  = grant_id_q;
         beat_cnt_d = '0;
      end else if (fire) begin
         beat_cnt_d = beat_cnt_q + 1'b1;
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         grant_id_q <= ID_WIDTH'(NUM_REQ - 1);
         last_id_q  <= ID_WIDTH'(NUM_REQ - 1);
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_id_q <= grant_id_d;
         last_id_q  <= last_id_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb_fifo_push_arbiter: random producers and a depth-2 FIFO around the arbiter, checked by a
// transaction-level reference model through an expected-push scoreboard.
module tb_fifo_push_arbiter;
   localparam int N  = 4;
   localparam int DW = 2;
   localparam int MB = 4;
   localparam int FIFO_DEPTH = 2;
   typedef struct {int id; int data;} beat_t;

   logic            clk = 0, reset = 0;
   logic [N-1:0]    req_valid = '0;
   logic [N*DW-1:0] req_data = '0;
   logic [N-1:0]    req_ready;
   logic            fifo_full = 0, fifo_push;
   logic [DW-1:0]   fifo_din;
   logic            grant_valid;
   logic [1:0]      grant_id;

   fifo_push_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .fifo_full   (fifo_full),
      .fifo_push   (fifo_push),
      .fifo_din    (fifo_din),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   always #5 clk = ~clk;

   int          n_checks = 0, n_fail = 0;
   beat_t       exp_q[$];
   int          ord_q[$];
   int          fifo_q[$];
   // model: owner = producer holding the FIFO (-1 none), last = previous owner, gid = shown grant_id
   int          m_owner, m_last, m_gid, m_beats, n_owner, n_last, n_gid, n_beats;
   bit          exp_gv, exp_fire, run = 0;
   int          exp_gid;
   logic [N-1:0] exp_ready;
   logic [N-1:0] acc_s = '0;
   bit          pushed_s = 0;
   logic [DW-1:0] din_s = '0;
   logic [DW-1:0] pend [N];

   task automatic chk(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_last  = N - 1;
      m_gid   = N - 1;
      m_beats = 0;
   endtask

   // Expected outputs for the current cycle plus the model state after the coming edge.
   task automatic predict();
      exp_gv   = m_owner >= 0;
      exp_gid  = m_gid;
      exp_ready = '0;
      exp_fire = 0;
      n_owner = m_owner; n_last = m_last; n_gid = m_gid; n_beats = m_beats;
      if (m_owner < 0) begin
         for (int k = 1; k <= N; k++)
            if (n_owner < 0 && req_valid[(m_last + k) % N]) begin
               n_owner = (m_last + k) % N;
               n_gid   = n_owner;
            end
      end else begin
         if (!fifo_full) exp_ready[m_owner] = 1'b1;
         if (!req_valid[m_owner]) begin
            n_owner = -1; n_last = m_owner; n_beats = 0;
         end else if (!fifo_full) begin
            exp_fire = 1;
            exp_q.push_back('{m_owner, int'(req_data[m_owner*DW +: DW])});
            ord_q.push_back(int'(req_data[m_owner*DW +: DW]));
            n_beats = m_beats + 1;
            if (n_beats == MB) begin
               n_owner = -1; n_last = m_owner; n_beats = 0;
            end
         end
      end
   endtask

   // Monitor: handshake sampling for the environment plus all per-cycle and per-push comparisons.
   always @(negedge clk) begin
      acc_s    = req_valid & req_ready & {N{~reset}};
      pushed_s = fifo_push & ~reset;
      din_s    = fifo_din;
      if (run && !reset) begin
         chk("grant_valid", int'(grant_valid), int'(exp_gv));
         chk("grant_id", int'(grant_id), exp_gid);
         chk("req_ready", int'(req_ready), int'(exp_ready));
         chk("ready_onehot", int'($countones(req_ready) <= 1), 1);
         if (fifo_push) begin
            chk("push_while_full", int'(fifo_full), 0);
            if (exp_q.size() == 0) chk("unexpected_push", 1, 0);
            else begin
               beat_t b;
               b = exp_q.pop_front();
               chk("push_id", int'(grant_id), b.id);
               chk("push_data", int'(fifo_din), b.data);
            end
         end
      end
   end

   initial begin
      int vpct, dpct, ppct;
      bit did_rst;
      did_rst = 0;
      for (int i = 0; i < N; i++) pend[i] = DW'($urandom);
      #1 reset = 1;
      #2;
      chk("rst_push", int'(fifo_push), 0);
      chk("rst_grant_valid", int'(grant_valid), 0);
      chk("rst_grant_id", int'(grant_id), N - 1);
      chk("rst_ready", int'(req_ready), 0);
      chk("rst_din", int'(fifo_din), 0);
      #14 reset = 0;
      model_reset();
      predict();
      run = 1;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         // light random load / saturated with draining FIFO / stalled FIFO
         vpct = 60; dpct = 10; ppct = 50;
         if (cyc >= 600 && cyc < 1000) begin vpct = 100; dpct = 0; ppct = 100; end
         if (cyc >= 1000 && cyc < 1300) begin vpct = 50; dpct = 5; ppct = 10; end
         @(posedge clk);
         #1;
         m_owner = n_owner; m_last = n_last; m_gid = n_gid; m_beats = n_beats;
         for (int i = 0; i < N; i++) begin
            if (acc_s[i]) begin
               pend[i] = DW'($urandom);
               req_valid[i] = 1'b0;
            end
            if (!req_valid[i]) req_valid[i] = $urandom_range(99) < vpct;
            else if ($urandom_range(99) < dpct) req_valid[i] = 1'b0;
            req_data[i*DW +: DW] = pend[i];
         end
         if (fifo_q.size() > 0 && $urandom_range(99) < ppct) begin
            int got;
            got = fifo_q.pop_front();
            if (ord_q.size() == 0) chk("fifo_order_extra", 1, 0);
            else chk("fifo_order", got, ord_q.pop_front());
         end
         if (pushed_s) fifo_q.push_back(int'(din_s));
         fifo_full = fifo_q.size() >= FIFO_DEPTH;
         predict();
         if (cyc >= 1300 && !did_rst && exp_fire) begin
            did_rst = 1;
            #2 reset = 1;
            #1;
            chk("midrst_push", int'(fifo_push), 0);
            chk("midrst_grant_valid", int'(grant_valid), 0);
            chk("midrst_grant_id", int'(grant_id), N - 1);
            chk("midrst_ready", int'(req_ready), 0);
            void'(exp_q.pop_back());
            void'(ord_q.pop_back());
            #3 reset = 0;
            req_valid[0] = 1'b1;
            model_reset();
            predict();
            chk("midrst_next_is_0", n_gid, 0);
         end
      end
      @(negedge clk);
      #1 run = 0;
      chk("midrst_done", int'(did_rst), 1);
      chk("leftover_pushes", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
